heartbeat_gen: RTL and testbench
================================

Name: heartbeat_gen

Overview:
Produces the periodic `heartbeat` pulse consumed by `watchdog_timer`. It is the transmitting end of the watchdog kick interface. A pulse is issued only while every masked upstream source (DSP sample strobe, command parser, DAC FIFO service, etc.) has shown activity within a timeout, so a hung subsystem starves the watchdog. Sits in the FPGA top level between the subsystem activity strobes and the `watchdog_timer` `heartbeat` input.

Parameters:
- NUM_SRC, 4, number of monitored activity sources.
- HB_PERIOD, 1000, cycles between heartbeat rising edges; must be ≥ 2.
- PULSE_W, 1, heartbeat high width in cycles; must be ≥ 1 and < HB_PERIOD.
- ALIVE_TIMEOUT, 4096, cycles without a strobe before a source is stale; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  generator run enable (same net as watchdog enable)
- src_strb  in  NUM_SRC  single-cycle activity strobe per source
- src_mask  in  NUM_SRC  1 = source participates in health check
- heartbeat  out  1  registered kick pulse to watchdog_timer
- hb_count  out  16  heartbeats issued; wraps at 16'hFFFF→0
- stalled  out  1  registered; high while a heartbeat is withheld
- stall_src  out  NUM_SRC  registered; stale masked sources latched at stall entry

Behaviour:
- Reset (async, rstn=0): state IDLE; heartbeat=0, hb_count=0, stalled=0, stall_src=0; period counter and all liveness counters cleared.
- Liveness, per source:
  - Counter width $clog2(ALIVE_TIMEOUT+1).
  - Cleared to 0 on src_strb; otherwise increments, saturating at ALIVE_TIMEOUT.
  - Held at 0 while enable=0.
  - stale[i] = (cnt==ALIVE_TIMEOUT) & src_mask[i], computed from the registered count. A strobe in cycle N clears stale from N+1.
  - healthy = ~|stale.
- States:
  - IDLE: enable=0. Outputs heartbeat=0, stalled=0. On enable=1: go to COUNT with period counter=0.
  - COUNT: period counter increments each cycle. At counter==HB_PERIOD-1 it wraps to 0, and:
    - healthy → PULSE: heartbeat=1 next cycle, hb_count+1.
    - unhealthy → STALL: stalled=1, stall_src=stale.
  - PULSE: heartbeat held 1 for exactly PULSE_W cycles, then back to COUNT. The period counter keeps running during PULSE, so rising edges are exactly HB_PERIOD apart.
  - STALL: heartbeat=0 and the period counter is held at 0. When healthy becomes 1: go to COUNT with stalled=0 and stall_src=0. The first heartbeat follows HB_PERIOD cycles later.
- Global rules:
  - enable=0 in any state → IDLE next cycle, heartbeat=0 that cycle. A pulse in progress is truncated. hb_count is retained.
  - src_mask changes take effect the following cycle. Unmasking a stale source in STALL releases the stall.
  - Latency: heartbeat rises 1 cycle after the wrap cycle. The first heartbeat rises HB_PERIOD cycles after enable is first sampled high.
  - All outputs are registered; no combinational input→output paths.

Optional Feature:
- Macro: HB_URGENT_EN. Adds input `wd_warning` (1 bit, from watchdog_timer).
- With the macro, in COUNT: if wd_warning=1 and healthy, enter PULSE immediately and reset the period counter to 0, ignoring the wrap. This has priority over a simultaneous wrap; hb_count increments once.
- Without the macro, the port is absent and the wrap is the only pulse trigger.

Decomposition:
- Package `hb_pkg`:
  - state enum hb_state_t {IDLE, COUNT, PULSE, STALL}
  - localparam HB_CNT_W=16
- Sub-module `hb_liveness_mon`: one saturating counter plus stale flag, instantiated NUM_SRC times via generate.
- The FSM and period counter live in `heartbeat_gen`.

Test Plan:
Bench parameters: HB_PERIOD=8, PULSE_W=2, ALIVE_TIMEOUT=16, NUM_SRC=2, src_mask=2'b11.
1. Reset release, enable=1, both sources strobing every 4 cycles → heartbeat high on cycles 8–9, 16–17, 24–25 after enable; hb_count=3; stalled never set.
2. Source 1 silent from cycle 0 → stale at cycle 16; wrap at 16 issues no pulse; stalled=1, stall_src=2'b10. Strobe source 1 at cycle 30 → stalled=0 at 32 (stale clears 31; one cycle STALL→COUNT); next heartbeat rises at cycle 40.
3. Same as 2 but src_mask=2'b01 → heartbeat continues every 8 cycles; stalled=0.
4. enable dropped during the first cycle of a pulse → heartbeat=0 next cycle, state IDLE, hb_count unchanged. Re-enable → next pulse rises 8 cycles later.
5. rstn asserted mid-pulse → heartbeat, hb_count, stalled and stall_src are 0 before the next clock edge.
6. HB_URGENT_EN defined: wd_warning=1 at period count 3, healthy → heartbeat rises next cycle, counter restarts at 0, next rise 8 cycles later. With wd_warning while stale → no pulse.

Source files
------------

// File: rtl/hb_pkg.sv
// rtl/hb_pkg.sv - state encoding and shared widths for the heartbeat generator
package hb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PULSE,
    STALL
  } hb_state_t;

  localparam int HB_CNT_W = 16;

endpackage

// File: rtl/hb_liveness_mon.sv
// rtl/hb_liveness_mon.sv - per-source saturating silence counter with masked stale flag
module hb_liveness_mon #(
  parameter int ALIVE_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable_i,
  input  logic strb_i,
  input  logic mask_i,
  output logic stale_o
);

  localparam int CW = $clog2(ALIVE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ALIVE_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || strb_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stale is taken from the registered count so a strobe clears it one cycle later.
  assign stale_o = (cnt_q == CNT_MAX) && mask_i;

endmodule

// File: rtl/heartbeat_gen.sv
// rtl/heartbeat_gen.sv - watchdog kick generator gated on upstream liveness
// Optional HB_URGENT_EN adds wd_warning for an immediate kick while counting.
module heartbeat_gen
  import hb_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int HB_PERIOD     = 1000,
  parameter int PULSE_W       = 1,
  parameter int ALIVE_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [NUM_SRC-1:0]  src_strb,
  input  logic [NUM_SRC-1:0]  src_mask,
`ifdef HB_URGENT_EN
  input  logic                wd_warning,
`endif
  output logic                heartbeat,
  output logic [HB_CNT_W-1:0] hb_count,
  output logic                stalled,
  output logic [NUM_SRC-1:0]  stall_src
);

  localparam int PER_W = $clog2(HB_PERIOD);
  localparam int PWC_W = $clog2(PULSE_W + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(HB_PERIOD - 1);
  localparam logic [PWC_W-1:0] PW_LAST  = PWC_W'(PULSE_W - 1);

  hb_state_t             state_q, state_d;
  logic [PER_W-1:0]      per_q, per_d;
  logic [PWC_W-1:0]      pw_q, pw_d;
  logic                  heartbeat_q, heartbeat_d;
  logic [HB_CNT_W-1:0]   hb_count_q, hb_count_d;
  logic                  stalled_q, stalled_d;
  logic [NUM_SRC-1:0]    stall_src_q, stall_src_d;
  logic [NUM_SRC-1:0]    stale;
  logic                  healthy;
  logic                  wrap;
  logic                  urgent;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_live
    hb_liveness_mon #(
      .ALIVE_TIMEOUT(ALIVE_TIMEOUT)
    ) u_mon (
      .clk     (clk),
      .rstn    (rstn),
      .enable_i(enable),
      .strb_i  (src_strb[i]),
      .mask_i  (src_mask[i]),
      .stale_o (stale[i])
    );
  end

  assign healthy = ~|stale;
  assign wrap    = (per_q == PER_LAST);

`ifdef HB_URGENT_EN
  assign urgent = wd_warning;
`else
  assign urgent = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    pw_d        = pw_q;
    heartbeat_d = heartbeat_q;
    hb_count_d  = hb_count_q;
    stalled_d   = stalled_q;
    stall_src_d = stall_src_q;

    if (!enable) begin
      state_d     = IDLE;
      per_d       = '0;
      pw_d        = '0;
      heartbeat_d = 1'b0;
      stalled_d   = 1'b0;
      stall_src_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          per_d   = '0;
        end
        COUNT: begin
          per_d = wrap ? '0 : per_q + PER_W'(1);
          // An urgent kick restarts the period so the next wrap is a full period away.
          if ((urgent && healthy) || (wrap && healthy)) begin
            state_d     = PULSE;
            per_d       = '0;
            pw_d        = '0;
            heartbeat_d = 1'b1;
            hb_count_d  = hb_count_q + HB_CNT_W'(1);
          end else if (wrap) begin
            state_d     = STALL;
            stalled_d   = 1'b1;
            stall_src_d = stale;
          end
        end
        PULSE: begin
          per_d = wrap ? '0 : per_q + PER_W'(1);
          if (pw_q == PW_LAST) begin
            state_d     = COUNT;
            pw_d        = '0;
            heartbeat_d = 1'b0;
          end else begin
            pw_d = pw_q + PWC_W'(1);
          end
        end
        STALL: begin
          per_d = '0;
          if (healthy) begin
            state_d     = COUNT;
            stalled_d   = 1'b0;
            stall_src_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      per_q       <= '0;
      pw_q        <= '0;
      heartbeat_q <= 1'b0;
      hb_count_q  <= '0;
      stalled_q   <= 1'b0;
      stall_src_q <= '0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      pw_q        <= pw_d;
      heartbeat_q <= heartbeat_d;
      hb_count_q  <= hb_count_d;
      stalled_q   <= stalled_d;
      stall_src_q <= stall_src_d;
    end
  end

  assign heartbeat = heartbeat_q;
  assign hb_count  = hb_count_q;
  assign stalled   = stalled_q;
  assign stall_src = stall_src_q;

endmodule

// File: tb/tb_heartbeat_gen.sv
// tb/tb_heartbeat_gen.sv - self-checking bench for heartbeat_gen with an event-level model
module tb_heartbeat_gen;

  localparam int NS = 2;
  localparam int P  = 8;
  localparam int PW = 2;
  localparam int TO = 16;
`ifdef HB_URGENT_EN
  localparam bit URG = 1'b1;
`else
  localparam bit URG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [NS-1:0] src_strb = '0;
  logic [NS-1:0] src_mask = '1;
  logic          wd_warning = 1'b0;
  logic          heartbeat;
  logic [15:0]   hb_count;
  logic          stalled;
  logic [NS-1:0] stall_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  heartbeat_gen #(
    .NUM_SRC(NS), .HB_PERIOD(P), .PULSE_W(PW), .ALIVE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .enable(enable),
    .src_strb(src_strb),
    .src_mask(src_mask),
`ifdef HB_URGENT_EN
    .wd_warning(wd_warning),
`endif
    .heartbeat(heartbeat),
    .hb_count(hb_count),
    .stalled(stalled),
    .stall_src(stall_src)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge time %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time-stamped liveness plus period arithmetic relative to the last period restart.
  int            n = 0;
  int            zero_at[NS];
  int            mode = 0;          // 0 idle, 1 running, 2 withheld
  int            run_start = 0;
  int            pulse_until = 0;
  int            age;
  bit            m_hb = 0, m_st = 0, healthy, hb_prev;
  logic [15:0]   m_cnt = '0;
  logic [NS-1:0] m_src = '0, mst;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = 0; m_hb = 0; m_st = 0; m_src = '0; m_cnt = '0;
      for (int i = 0; i < NS; i++) zero_at[i] = n;
    end else begin
      n = n + 1;
      for (int i = 0; i < NS; i++) begin
        age = n - 1 - zero_at[i];
        if (age > TO) age = TO;
        mst[i] = (age == TO) && src_mask[i];
      end
      healthy = (mst == '0);
      for (int i = 0; i < NS; i++)
        if (!enable || src_strb[i]) zero_at[i] = n;
      hb_prev = m_hb;
      if (!enable) begin
        mode = 0; m_hb = 0; m_st = 0; m_src = '0;
      end else if (mode == 0) begin
        mode = 1; run_start = n;
      end else if (mode == 2) begin
        if (healthy) begin
          mode = 1; run_start = n; m_st = 0; m_src = '0;
        end
      end else begin
        if (m_hb && n >= pulse_until) m_hb = 0;
        if ((!hb_prev && URG && wd_warning && healthy) ||
            ((n - run_start) % P == 0 && healthy)) begin
          m_hb = 1; pulse_until = n + PW; run_start = n; m_cnt = m_cnt + 16'd1;
        end else if ((n - run_start) % P == 0) begin
          mode = 2; m_st = 1; m_src = mst;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("heartbeat", heartbeat, m_hb);
      chk("hb_count", hb_count, m_cnt);
      chk("stalled", stalled, m_st);
      chk("stall_src", stall_src, m_src);
    end
  end

  // Stimulus
  int per[NS];
  int rate[NS];
  int tc = 0;
  int force_at = -1;
  logic [NS-1:0] force_bits = '0;
  bit rnd = 0;
  int E, E2;

  task automatic tick();
    @(negedge clk);
    tc++;
    for (int i = 0; i < NS; i++) begin
      if (rnd) begin
        if (rate[i] != 0) src_strb[i] = ($urandom_range(0, rate[i] - 1) == 0);
        else src_strb[i] = 1'b0;
      end else begin
        src_strb[i] = (per[i] != 0) && (tc % per[i] == 0);
      end
    end
    if (n == force_at) src_strb = src_strb | force_bits;
  endtask

  task automatic wait_to(input int target);
    int g;
    g = 0;
    while (n < target && g < 2000) begin
      tick();
      g++;
    end
    if (n != target) chk("wait_bound", n, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; enable = 1'b0; src_strb = '0; wd_warning = 1'b0;
    force_at = -1; rnd = 0;
    #1;
    chk("rst_heartbeat", heartbeat, 0);
    chk("rst_hb_count", hb_count, 0);
    chk("rst_stalled", stalled, 0);
    chk("rst_stall_src", stall_src, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tc = 0;
  endtask

  task automatic start();
    tick();
    enable = 1'b1;
    E = n + 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: healthy sources, regular kicks
    do_reset(); src_mask = 2'b11; per = '{4, 4};
    start();
    wait_to(E + 7);  chk("t1_hb_e7", heartbeat, 0);
    wait_to(E + 8);  chk("t1_hb_e8", heartbeat, 1);
    wait_to(E + 9);  chk("t1_hb_e9", heartbeat, 1);
    wait_to(E + 10); chk("t1_hb_e10", heartbeat, 0);
    wait_to(E + 16); chk("t1_hb_e16", heartbeat, 1);
    wait_to(E + 24); chk("t1_hb_e24", heartbeat, 1);
    wait_to(E + 26); chk("t1_count", hb_count, 3); chk("t1_stalled", stalled, 0);

    // 2: source 1 silent, stall, then recovery
    do_reset(); src_mask = 2'b11; per = '{4, 0};
    start();
    force_at = E + 30; force_bits = 2'b10;
    wait_to(E + 8);  chk("t2_hb_e8", heartbeat, 1);
    wait_to(E + 15); chk("t2_stalled_e15", stalled, 0);
    wait_to(E + 16); chk("t2_stalled_e16", stalled, 1);
    chk("t2_src_e16", stall_src, 2'b10); chk("t2_hb_e16", heartbeat, 0);
    wait_to(E + 31); chk("t2_stalled_e31", stalled, 1);
    wait_to(E + 32); chk("t2_stalled_e32", stalled, 0); chk("t2_src_e32", stall_src, 0);
    wait_to(E + 39); chk("t2_hb_e39", heartbeat, 0);
    wait_to(E + 40); chk("t2_hb_e40", heartbeat, 1); chk("t2_count", hb_count, 2);
    force_at = -1;

    // 3: silent source masked out
    do_reset(); src_mask = 2'b01; per = '{4, 0};
    start();
    wait_to(E + 16); chk("t3_hb_e16", heartbeat, 1); chk("t3_stalled", stalled, 0);
    wait_to(E + 24); chk("t3_hb_e24", heartbeat, 1);
    wait_to(E + 32); chk("t3_count", hb_count, 4);

    // 4: enable dropped in first pulse cycle, then re-enabled
    do_reset(); src_mask = 2'b11; per = '{4, 4};
    start();
    wait_to(E + 8); chk("t4_hb_e8", heartbeat, 1);
    enable = 1'b0;
    wait_to(E + 9); chk("t4_hb_e9", heartbeat, 0); chk("t4_count_kept", hb_count, 1);
    wait_to(E + 12);
    enable = 1'b1; E2 = n + 1;
    wait_to(E2 + 7); chk("t4_hb_re7", heartbeat, 0);
    wait_to(E2 + 8); chk("t4_hb_re8", heartbeat, 1); chk("t4_count_re", hb_count, 2);

    // 5: asynchronous reset in the middle of a pulse
    wait_to(E2 + 16); chk("t5_hb_pre", heartbeat, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_hb", heartbeat, 0); chk("t5_count", hb_count, 0);
    chk("t5_stalled", stalled, 0); chk("t5_src", stall_src, 0);
    enable = 1'b0;
    @(negedge clk); rstn = 1'b1; tc = 0;

`ifdef HB_URGENT_EN
    // 6: urgent kick when healthy, ignored when stale
    do_reset(); src_mask = 2'b11; per = '{4, 4};
    start();
    wait_to(E + 3); wd_warning = 1'b1;
    wait_to(E + 4); wd_warning = 1'b0;
    chk("t6_hb_e4", heartbeat, 1); chk("t6_count_e4", hb_count, 1);
    wait_to(E + 11); chk("t6_hb_e11", heartbeat, 0);
    wait_to(E + 12); chk("t6_hb_e12", heartbeat, 1); chk("t6_count_e12", hb_count, 2);
    do_reset(); src_mask = 2'b11; per = '{4, 0};
    start();
    wait_to(E + 15); wd_warning = 1'b1;
    wait_to(E + 16); wd_warning = 1'b0;
    chk("t6_stale_hb", heartbeat, 0); chk("t6_stale_stalled", stalled, 1);
`endif

    // Randomized segments checked against the model every cycle
    do_reset();
    rnd = 1;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 3))
          0: rate[i] = 2;
          1: rate[i] = 6;
          2: rate[i] = 14;
          default: rate[i] = 0;
        endcase
      end
      src_mask = NS'($urandom);
      enable = ($urandom_range(0, 5) != 0);
      for (int c = 0; c < 100; c++) begin
        tick();
        wd_warning = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 199) == 0) enable = ~enable;
        if ($urandom_range(0, 49) == 0) src_mask = NS'($urandom);
      end
    end
    rnd = 0;
    enable = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
